// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive framing controller.
//   UART_BYTE_W  : width of one received byte
//   rx_state_e   : receiver handshake FSM states (ST_RUN accepts bytes, ST_ACK drops enable)
//   byte_slot    : maps a byte index to its slot in the assembled word
package uart_rx_frame_ctrl_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ACK = 1'b1
    } rx_state_e;

    function automatic int unsigned byte_slot(input int unsigned idx, input int unsigned bytes,
                                              input bit msb_first);
        return msb_first ? (bytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Bus between the UART receiver / word consumer and the framing controller.
//   Rx_Done_Sig, Rx_Data : byte strobe and byte from the receiver
//   Rx_En_Sig            : receiver enable
//   Word_Data/Valid/Ready: assembled-word handshake toward user logic
//   Overrun_Sig, Timeout_Sig, Chk_Err_Sig : one-clock status pulses
// Modports: slave = controller side, master = receiver/consumer side.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned BYTES = 4
);
    import uart_rx_frame_ctrl_pkg::*;

    logic                         Rx_Done_Sig;
    logic [UART_BYTE_W-1:0]       Rx_Data;
    logic                         Rx_En_Sig;
    logic [UART_BYTE_W*BYTES-1:0] Word_Data;
    logic                         Word_Valid;
    logic                         Word_Ready;
    logic                         Overrun_Sig;
    logic                         Timeout_Sig;
    logic                         Chk_Err_Sig;

    modport slave (
        input  Rx_Done_Sig, Rx_Data, Word_Ready,
        output Rx_En_Sig, Word_Data, Word_Valid, Overrun_Sig, Timeout_Sig, Chk_Err_Sig
    );

    modport master (
        output Rx_Done_Sig, Rx_Data, Word_Ready,
        input  Rx_En_Sig, Word_Data, Word_Valid, Overrun_Sig, Timeout_Sig, Chk_Err_Sig
    );

endinterface

// File: rtl/uart_rx_frame_ctrl_fifo.sv
// uart_word_fifo: DEPTH-entry word buffer for completed frames.
//   CLK, RST_n : clock, asynchronous active-low reset
//   push, din  : write request and data; accepted when not full or when popping on the same edge
//   full       : DEPTH entries held
//   pop, dout  : read request and head entry (dout reads 0 while empty)
//   empty      : no entries held
module uart_word_fifo
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    // When full, the popped slot is the one being written, so push+pop is safe.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd_en) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (!wr_en && rd_en) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: sits between a UART receiver and user logic. Keeps the receiver enabled,
// assembles BYTES consecutive bytes into one word, buffers completed words in a DEPTH-entry
// FIFO read out with valid/ready, discards partial frames after TIMEOUT_CYC idle clocks and
// pulses Overrun_Sig when a completed word meets a full buffer.
// Ports:
//   CLK, RST_n : clock, asynchronous active-low reset
//   bus        : uart_rx_frame_ctrl_if.slave (receiver strobe/data/enable, word handshake,
//                status pulses)
// Optional feature: define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte to each
// frame; mismatching frames are dropped and pulse Chk_Err_Sig. Without it Chk_Err_Sig is 0.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int unsigned BYTES       = 4,
    parameter int unsigned DEPTH       = 4,
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    uart_rx_frame_ctrl_if.slave  bus
);

    localparam int unsigned WORD_W = UART_BYTE_W * BYTES;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int unsigned LAST_IDX = BYTES;      // index of the checksum byte
`else
    localparam int unsigned LAST_IDX = BYTES - 1;
`endif
    localparam int unsigned IW = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    rx_state_e                               state_q;
    logic                                    rx_en_q;
    logic [IW-1:0]                           idx_q, idx_d;
    logic [BYTES-1:0][UART_BYTE_W-1:0]       word_q, word_d;
    logic [TW-1:0]                           tmo_q, tmo_d;
    logic                                    timeout_q, overrun_q;
    logic                                    capture, push, pop, tmo_hit;
    logic                                    fifo_full, fifo_empty;
    logic [WORD_W-1:0]                       fifo_dout;
    int unsigned                             slot;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [UART_BYTE_W-1:0]                  xor_q, xor_d;
    logic                                    chk_fail, chk_err_q;
`endif

    // Bytes are only taken while the FSM is in ST_RUN; ST_ACK masks Rx_Done_Sig.
    assign capture = (state_q == ST_RUN) && bus.Rx_Done_Sig;
    assign pop     = !fifo_empty && bus.Word_Ready;

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        push    = 1'b0;
        slot    = byte_slot(32'(idx_q), BYTES, MSB_FIRST);
`ifdef UART_FRAME_CHECKSUM_EN
        xor_d    = xor_q;
        chk_fail = 1'b0;
`endif
        if (capture) begin
            idx_d = (idx_q == IW'(LAST_IDX)) ? '0 : idx_q + IW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
            if (idx_q == IW'(BYTES)) begin
                xor_d = '0;
                if (bus.Rx_Data == xor_q) begin
                    push = 1'b1;
                end else begin
                    chk_fail = 1'b1;
                end
            end else begin
                xor_d = xor_q ^ bus.Rx_Data;
                for (int unsigned s = 0; s < BYTES; s++) begin
                    if (s == slot) word_d[s] = bus.Rx_Data;
                end
            end
`else
            for (int unsigned s = 0; s < BYTES; s++) begin
                if (s == slot) word_d[s] = bus.Rx_Data;
            end
            // The word pushed includes the byte captured on this edge.
            push = (idx_q == IW'(LAST_IDX));
`endif
        end

        // Idle counter only runs mid-frame; a capture on the expiry clock wins.
        if (capture || (idx_q == '0) || (TIMEOUT_CYC == 0)) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            tmo_hit = 1'b1;
            tmo_d   = '0;
            idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            xor_d   = '0;
`endif
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Receiver handshake FSM: enable drops for exactly one clock after every capture.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_RUN;
            rx_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (capture) begin
                        state_q <= ST_ACK;
                        rx_en_q <= 1'b0;
                    end else begin
                        rx_en_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_RUN;
                    rx_en_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                    rx_en_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            idx_q     <= '0;
            word_q    <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            word_q    <= word_d;
            tmo_q     <= tmo_d;
            timeout_q <= tmo_hit;
            overrun_q <= push && fifo_full && !pop;
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            xor_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            chk_err_q <= chk_fail;
        end
    end
    assign bus.Chk_Err_Sig = chk_err_q;
`else
    assign bus.Chk_Err_Sig = 1'b0;
`endif

    uart_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_n (RST_n),
        .push  (push),
        .din   (word_d),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign bus.Rx_En_Sig   = rx_en_q;
    assign bus.Word_Data   = fifo_dout;
    assign bus.Word_Valid  = !fifo_empty;
    assign bus.Overrun_Sig = overrun_q;
    assign bus.Timeout_Sig = timeout_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl. Two instances share the byte stream:
//   dut_a : LSB-first, DEPTH=4, TIMEOUT_CYC=100 (assembly, overrun, timeout, checksum, reset)
//   dut_b : MSB-first (byte order and pop)
// Works with or without UART_FRAME_CHECKSUM_EN; with it every frame carries an XOR byte.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b0;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned n_tmo = 0;
    int unsigned n_ovr = 0;

    logic [31:0] exp_w [4] = '{32'h14131211, 32'h24232221, 32'h34333231, 32'h44434241};

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.BYTES(4)) if_a ();
    uart_rx_frame_ctrl_if #(.BYTES(4)) if_b ();

    assign if_a.Rx_Done_Sig = rx_done;
    assign if_a.Rx_Data     = rx_data;
    assign if_a.Word_Ready  = ready_a;
    assign if_b.Rx_Done_Sig = rx_done;
    assign if_b.Rx_Data     = rx_data;
    assign if_b.Word_Ready  = ready_b;

    uart_rx_frame_ctrl #(
        .BYTES(4), .DEPTH(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(100)
    ) dut_a (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (if_a)
    );

    uart_rx_frame_ctrl #(
        .BYTES(4), .DEPTH(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(50000)
    ) dut_b (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (if_b)
    );

    always @(negedge clk) begin
        if (rst_n && (if_a.Timeout_Sig === 1'b1)) n_tmo++;
        if (rst_n && (if_a.Overrun_Sig === 1'b1)) n_ovr++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture edge only; Rx_En must be low right after it.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check_eq("rx_en_low", 64'(if_a.Rx_En_Sig), 64'd0);
    endtask

    task automatic ack();
        tick();
        check_eq("rx_en_high", 64'(if_a.Rx_En_Sig), 64'd1);
    endtask

    // Returns right after the frame's final capture edge.
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0); ack();
        send_byte(b1); ack();
        send_byte(b2); ack();
        send_byte(b3);
`ifdef UART_FRAME_CHECKSUM_EN
        ack();
        send_byte(b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    task automatic pop_a();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check_eq("rst_rx_en", 64'(if_a.Rx_En_Sig), 64'd0);
        check_eq("rst_valid", 64'(if_a.Word_Valid), 64'd0);
        check_eq("rst_data", 64'(if_a.Word_Data), 64'd0);
        check_eq("rst_ovr", 64'(if_a.Overrun_Sig), 64'd0);
        check_eq("rst_tmo", 64'(if_a.Timeout_Sig), 64'd0);
        check_eq("rst_chk", 64'(if_a.Chk_Err_Sig), 64'd0);
        rst_n = 1'b1;
        ack();

        // 1/2: assembly order, latency, pop
        send_byte(8'h11); ack();
        send_byte(8'h22); ack();
        send_byte(8'h33); ack();
        check_eq("valid_before_last", 64'(if_a.Word_Valid), 64'd0);
        send_byte(8'h44);
`ifdef UART_FRAME_CHECKSUM_EN
        check_eq("valid_before_cs", 64'(if_a.Word_Valid), 64'd0);
        ack();
        send_byte(8'h44);
`endif
        check_eq("lsb_valid", 64'(if_a.Word_Valid), 64'd1);
        check_eq("lsb_word", 64'(if_a.Word_Data), 64'h44332211);
        check_eq("msb_valid", 64'(if_b.Word_Valid), 64'd1);
        check_eq("msb_word", 64'(if_b.Word_Data), 64'h11223344);
        check_eq("chk_quiet", 64'(if_a.Chk_Err_Sig), 64'd0);
        ack();
        check_eq("word_hold", 64'(if_a.Word_Data), 64'h44332211);
        ready_a = 1'b1;
        ready_b = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("pop_valid_a", 64'(if_a.Word_Valid), 64'd0);
        check_eq("pop_valid_b", 64'(if_b.Word_Valid), 64'd0);

        // 3: overrun with stalled consumer, then ordered drain
        for (int k = 1; k <= 5; k++) begin
            send_word(8'(16*k+1), 8'(16*k+2), 8'(16*k+3), 8'(16*k+4));
            check_eq("ovr_pulse", 64'(if_a.Overrun_Sig), (k == 5) ? 64'd1 : 64'd0);
            ack();
        end
        check_eq("ovr_one_clk", 64'(if_a.Overrun_Sig), 64'd0);
        check_eq("ovr_count", 64'(n_ovr), 64'd1);
        check_eq("ovr_head_stable", 64'(if_a.Word_Data), 64'h14131211);
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", 64'(if_a.Word_Valid), 64'd1);
            check_eq("drain_word", 64'(if_a.Word_Data), 64'(exp_w[i]));
            tick();
        end
        ready_a = 1'b0;
        check_eq("drain_empty", 64'(if_a.Word_Valid), 64'd0);

        // 4: timeout after 100 idle clocks mid-frame
        send_byte(8'hAA); ack();
        send_byte(8'hBB); ack();
        repeat (98) tick();
        check_eq("tmo_early", 64'(if_a.Timeout_Sig), 64'd0);
        tick();
        check_eq("tmo_pulse", 64'(if_a.Timeout_Sig), 64'd1);
        tick();
        check_eq("tmo_one_clk", 64'(if_a.Timeout_Sig), 64'd0);
        send_word(8'h01, 8'h02, 8'h03, 8'h04);
        check_eq("post_tmo_valid", 64'(if_a.Word_Valid), 64'd1);
        check_eq("post_tmo_word", 64'(if_a.Word_Data), 64'h04030201);
        ack();
        pop_a();

        // 4b: byte arriving on the expiry clock is captured
        send_byte(8'hAA); ack();
        repeat (98) tick();
        rx_data = 8'hCC;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check_eq("race_rx_en", 64'(if_a.Rx_En_Sig), 64'd0);
        check_eq("race_no_tmo", 64'(if_a.Timeout_Sig), 64'd0);
        ack();
        send_byte(8'hDD); ack();
        send_byte(8'hEE);
`ifdef UART_FRAME_CHECKSUM_EN
        ack();
        send_byte(8'h55);
`endif
        check_eq("race_valid", 64'(if_a.Word_Valid), 64'd1);
        check_eq("race_word", 64'(if_a.Word_Data), 64'hEEDDCCAA);
        ack();
        pop_a();
        check_eq("tmo_count", 64'(n_tmo), 64'd1);

`ifdef UART_FRAME_CHECKSUM_EN
        // 5: checksum match and mismatch
        send_word(8'h01, 8'h02, 8'h03, 8'h04);
        check_eq("cs_ok_valid", 64'(if_a.Word_Valid), 64'd1);
        check_eq("cs_ok_word", 64'(if_a.Word_Data), 64'h04030201);
        check_eq("cs_ok_noerr", 64'(if_a.Chk_Err_Sig), 64'd0);
        ack();
        pop_a();
        send_byte(8'h01); ack();
        send_byte(8'h02); ack();
        send_byte(8'h03); ack();
        send_byte(8'h04); ack();
        send_byte(8'hFF);
        check_eq("cs_bad_err", 64'(if_a.Chk_Err_Sig), 64'd1);
        check_eq("cs_bad_nopush", 64'(if_a.Word_Valid), 64'd0);
        ack();
        check_eq("cs_err_one_clk", 64'(if_a.Chk_Err_Sig), 64'd0);
        send_word(8'h05, 8'h06, 8'h07, 8'h08);
        check_eq("cs_after_bad", 64'(if_a.Word_Data), 64'h08070605);
        ack();
        pop_a();
`endif

        // 6: reset mid-frame with a word buffered
        send_word(8'h21, 8'h22, 8'h23, 8'h24);
        ack();
        send_byte(8'h31); ack();
        send_byte(8'h32); ack();
        check_eq("pre_rst_valid", 64'(if_a.Word_Valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rx_en", 64'(if_a.Rx_En_Sig), 64'd0);
        check_eq("mid_rst_valid", 64'(if_a.Word_Valid), 64'd0);
        check_eq("mid_rst_data", 64'(if_a.Word_Data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ack();
        send_word(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        check_eq("post_rst_valid", 64'(if_a.Word_Valid), 64'd1);
        check_eq("post_rst_word", 64'(if_a.Word_Data), 64'h0D0C0B0A);
        ack();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
